// File: rtl/sound_frame_sequencer.sv
// sound_frame_sequencer
// 512 Hz APU frame-sequencer timebase with length/sweep/envelope strobes,
// plus the four channel length counters and the NR52[3:0] channel status.
// Everything visible on the ports comes straight from a register.

module sound_frame_sequencer #(
  parameter int CLK_DIV = 8192
) (
  input  logic       iClock,
  input  logic       iReset,
  input  logic       iMasterEnable,
  input  logic [3:0] iTrigger,
  input  logic [3:0] iLengthEnable,
  input  logic [3:0] iLengthWr,
  input  logic [7:0] iLengthData,
  input  logic [3:0] iChannelKill,
  output logic [2:0] oStep,
  output logic       oLengthTick,
  output logic       oSweepTick,
  output logic       oEnvelopeTick,
  output logic [3:0] oChannelOn
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

  logic [PRE_W-1:0] prescale_q, prescale_d;
  logic [2:0]       step_q, step_d;
  logic             lengthTick_q, lengthTick_d;
  logic             sweepTick_q, sweepTick_d;
  logic             envTick_q, envTick_d;
  logic [3:0]       chOn_q, chOn_d;

  // Prescaler and step counter; strobes are decoded from the step being entered
  always_comb begin
    prescale_d   = prescale_q;
    step_d       = step_q;
    lengthTick_d = 1'b0;
    sweepTick_d  = 1'b0;
    envTick_d    = 1'b0;
    if (!iMasterEnable) begin
      prescale_d = '0;
      step_d     = 3'd7;
    end else if (prescale_q == PRE_LAST) begin
      prescale_d   = '0;
      step_d       = step_q + 3'd1;
      lengthTick_d = ~step_d[0];
      sweepTick_d  = (step_d == 3'd2) || (step_d == 3'd6);
      envTick_d    = (step_d == 3'd7);
    end else begin
      prescale_d = prescale_q + PRE_W'(1);
    end
  end

  // Sequencer state register
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      prescale_q   <= '0;
      step_q       <= 3'd7;
      lengthTick_q <= 1'b0;
      sweepTick_q  <= 1'b0;
      envTick_q    <= 1'b0;
    end else begin
      prescale_q   <= prescale_d;
      step_q       <= step_d;
      lengthTick_q <= lengthTick_d;
      sweepTick_q  <= sweepTick_d;
      envTick_q    <= envTick_d;
    end
  end

  // One length counter per channel; channel 3 (index 2) counts to 256, the rest to 64
  for (genvar n = 0; n < 4; n++) begin : gLen
    localparam int CW = (n == 2) ? 9 : 7;
    localparam logic [CW-1:0] LEN_MAX = (n == 2) ? CW'(256) : CW'(64);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] wrVal;
    logic          on_d;

    // Next counter value and on/off status: kill beats trigger beats write beats tick
    always_comb begin
      cnt_d = cnt_q;
      on_d  = chOn_q[n];
      wrVal = (n == 2) ? (LEN_MAX - CW'(iLengthData))
                       : (LEN_MAX - CW'(iLengthData[5:0]));
      if (!iMasterEnable) begin
        cnt_d = '0;
        on_d  = 1'b0;
      end else begin
        if (iTrigger[n]) begin
          on_d = 1'b1;
          if (iLengthWr[n]) begin
            cnt_d = (wrVal == '0) ? LEN_MAX : wrVal;
          end else if (cnt_q == '0) begin
            cnt_d = LEN_MAX;
          end
        end else if (iLengthWr[n]) begin
          cnt_d = wrVal;
        end else if (lengthTick_q && iLengthEnable[n] && (cnt_q != '0)) begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            on_d = 1'b0;
          end
        end
        if (iChannelKill[n]) begin
          on_d = 1'b0;
        end
      end
    end

    // Length counter register
    always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign chOn_d[n] = on_d;
  end

  // Channel status register (NR52[3:0])
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      chOn_q <= 4'b0000;
    end else begin
      chOn_q <= chOn_d;
    end
  end

  assign oStep         = step_q;
  assign oLengthTick   = lengthTick_q;
  assign oSweepTick    = sweepTick_q;
  assign oEnvelopeTick = envTick_q;
  assign oChannelOn    = chOn_q;

endmodule

// File: doc/sound_frame_sequencer.md
Name: sound_frame_sequencer

Overview:
Generates the 512 Hz APU frame-sequencer timebase for the sound subsystem and issues one-cycle length (256 Hz), sweep (128 Hz) and envelope (64 Hz) strobes to the four channel modules. Owns the four channel length counters and the per-channel on/off status. That status gates the channel outputs presented to the left/right mixer and is read back as NR52[3:0]. It sits between the register file (NR52, NRx1, NRx4) and the channel generators/mixer.

Parameters:
CLK_DIV, 8192, iClock cycles per sequencer step; 4194304/8192 = 512 Hz; must be ≥2.

Ports:
iClock  in  1  CPU clock, 4194304 Hz
iReset  in  1  asynchronous active-high reset
iMasterEnable  in  1  NR52[7]; 0 = APU powered off
iTrigger  in  4  one-cycle pulses, bit n = channel n+1 trigger (NRx4[7] write)
iLengthEnable  in  4  level, bit n = NRx4[6] of channel n+1
iLengthWr  in  4  one-cycle pulses, bit n = NRx1 length field written
iLengthData  in  8  length field; channels 1/2/4 use [5:0], channel 3 uses [7:0]
iChannelKill  in  4  level, bit n forces channel n+1 off (DAC off / sweep overflow)
oStep  out  3  current sequencer step 0..7
oLengthTick  out  1  one-cycle strobe
oSweepTick  out  1  one-cycle strobe
oEnvelopeTick  out  1  one-cycle strobe
oChannelOn  out  4  NR52[3:0] channel status

Behaviour:
- Reset (async, iReset=1): prescaler=0, oStep=7, all strobes=0, all length counters=0, oChannelOn=4'b0000.
- Prescaler: counts 0..CLK_DIV-1 while iMasterEnable=1.
  - In the cycle it equals CLK_DIV-1 it wraps to 0, and oStep advances to (oStep+1) mod 8 on that same edge.
  - Strobes are registered, high for exactly the one cycle after the wrap edge, and decoded from the new step:
    - oLengthTick: steps 0,2,4,6
    - oSweepTick: steps 2,6
    - oEnvelopeTick: step 7
  - First step after reset/enable is 0, reached CLK_DIV cycles after enable.
- Length counters:
  - Ch1/2/4: 7 bit, max 64. Ch3: 9 bit, max 256.
  - iLengthWr[n]: counter <= max − data (data masked to 6 bits for ch1/2/4).
  - iTrigger[n]: oChannelOn[n] <= 1. If counter==0, counter <= max; otherwise the counter is unchanged.
  - Length event: oLengthTick cycle with iLengthEnable[n]=1 and counter≠0 → counter decrements. If the result is 0, oChannelOn[n] <= 0 on the same edge.
- Priority per channel, same cycle, highest first:
  1. iChannelKill: oChannelOn[n]=0. The counter still follows the rules below.
  2. iTrigger: no decrement that cycle. Counter reloads to max only if 0.
  3. iLengthWr: the written value is loaded and the tick is ignored.
  4. Tick decrement.
- Simultaneous iTrigger and iLengthWr on a channel: the counter takes max − data, or max if max − data would be 0 (impossible by range; not reachable). oChannelOn goes to 1.
- iTrigger while iChannelKill=1: oChannelOn stays 0.
- Counter wrap: never decrements below 0. Counter = max is legal (64 for ch1/2/4, 256 for ch3).
- iMasterEnable=0 (power-off), synchronous, every cycle it is low:
  - prescaler=0, oStep=7, strobes=0, all counters=0, oChannelOn=0.
  - iTrigger and iLengthWr are ignored.
  - Re-enable restarts the sequencer cleanly from step 7→0.
- Mid-operation reset or power-off discards any pending strobe. No strobe is emitted in the cycle iMasterEnable goes low.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- CLK_DIV=4, enable held 40 cycles:
  - oStep sequence is 0..7 then wraps to 0.
  - oLengthTick fires 4 times per 8 steps, oSweepTick twice (steps 2,6), oEnvelopeTick once (step 7).
  - Each strobe is 1 cycle wide and its first occurrence is 4 cycles after enable.
- Ch2 length:
  - iLengthWr[1] with data 6'd62 → counter=2; trigger; iLengthEnable[1]=1.
  - oChannelOn[1]=1 until the 2nd oLengthTick, then 0 on that edge.
- Ch3:
  - Trigger with counter=0 → counter=256.
  - iLengthEnable[2]=1 → off after exactly 256 length ticks.
- Trigger coincident with oLengthTick on ch1 (counter=5, enabled) → counter stays 5, oChannelOn[0]=1.
- iChannelKill[3]=1 then iTrigger[3] → oChannelOn[3] stays 0. Release kill and retrigger → 1.
- iMasterEnable dropped mid-step (oStep=3, channels on):
  - Next cycle oStep=7, oChannelOn=0, counters 0, no strobes.
  - Async iReset pulse mid-count gives the same result with no clock edge.
